data_mem_stage: RTL and testbench

DATA_MEM_STAGE -- requirements
Module: data_mem_stage

---
 rtl/data_mem_stage.sv | 155 +++++++++++++++
 tb/tb_data_mem_stage.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_stage.sv
// data_mem_stage: EX/MEM and MEM/WB pipeline registers around a word-addressed
// data memory with a fixed multi-cycle access latency (MEM_LAT wait cycles).
// Optional build macro MISALIGN_TRAP_EN: misaligned loads/stores are squashed
// and flagged on trap.
module data_mem_stage #(
    parameter int DEPTH   = 256,
    parameter int MEM_LAT = 2
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [1:0]  EXMWB,
    input  logic [2:0]  EXMM,
    input  logic [31:0] EXALUOut,
    input  logic [31:0] EXMWriteDataIn,
    input  logic [4:0]  regtopass,
    output logic [31:0] MEMALUOut,
    output logic [4:0]  EXMEMRegRd,
    output logic [1:0]  EXMEM_RegWrite,
    output logic [4:0]  MEMWBRegRd,
    output logic [1:0]  MEMWB_RegWrite,
    output logic [31:0] datatowrite,
    output logic        stall,
    output logic        trap
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] LAT_M1 = (MEM_LAT > 0) ? 4'(MEM_LAT - 1) : 4'd0;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;

    // EX/MEM register
    logic [1:0]  em_wb;
    logic [2:0]  em_m;
    logic [31:0] em_alu;
    logic [31:0] em_wdata;
    logic [4:0]  em_rd;

    // MEM/WB register
    logic [1:0]  mw_wb;
    logic [31:0] mw_alu;
    logic [31:0] mw_ldata;
    logic [4:0]  mw_rd;

    logic [31:0] mem [DEPTH];
    logic [AW-1:0] idx;
    logic [31:0] rd_data;
    logic        mem_op, misalign, misalign_op, do_write;
    logic        unused_branch;

    assign mem_op  = em_m[0] | em_m[1];
    // Upper address bits are dropped so accesses wrap around the array.
    assign idx     = em_alu[AW+1:2];
    assign rd_data = mem[idx];

`ifdef MISALIGN_TRAP_EN
    assign misalign = (em_alu[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign misalign_op   = mem_op & misalign;
    // Completion is any cycle without stall; that is the single write edge.
    assign do_write      = ~stall & em_m[1] & ~misalign_op;
    // Branch bit is carried through EX/MEM but has no consumer in this stage.
    assign unused_branch = em_m[2];

    assign MEMALUOut      = em_alu;
    assign EXMEMRegRd     = em_rd;
    assign EXMEM_RegWrite = em_wb;
    assign MEMWBRegRd     = mw_rd;
    assign MEMWB_RegWrite = mw_wb;
    assign datatowrite    = mw_wb[1] ? mw_ldata : mw_alu;

    // Latency FSM: next state, wait counter and stall request
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        stall   = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op && (MEM_LAT > 0)) begin
                    stall   = 1'b1;
                    state_n = BUSY;
                    cnt_n   = LAT_M1;
                end
            end
            BUSY: begin
                if (cnt != 4'd0) begin
                    stall = 1'b1;
                    cnt_n = cnt - 4'd1;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // FSM state and counter registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // EX/MEM capture; holds while the memory access is in progress
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            em_wb    <= 2'b00;
            em_m     <= 3'b000;
            em_alu   <= 32'd0;
            em_wdata <= 32'd0;
            em_rd    <= 5'd0;
        end else if (!stall) begin
            em_wb    <= EXMWB;
            em_m     <= EXMM;
            em_alu   <= EXALUOut;
            em_wdata <= EXMWriteDataIn;
            em_rd    <= regtopass;
        end
    end

    // MEM/WB capture; a stall cycle inserts a bubble by clearing the WB field
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            mw_wb    <= 2'b00;
            mw_alu   <= 32'd0;
            mw_ldata <= 32'd0;
            mw_rd    <= 5'd0;
            trap     <= 1'b0;
        end else if (stall) begin
            mw_wb    <= 2'b00;
            trap     <= 1'b0;
        end else begin
            mw_wb    <= misalign_op ? 2'b00 : em_wb;
            mw_alu   <= em_alu;
            mw_ldata <= rd_data;
            mw_rd    <= em_rd;
            trap     <= misalign_op;
        end
    end

    // Data array write; contents deliberately survive reset
    always_ff @(posedge clock) begin
        if (do_write)
            mem[idx] <= em_wdata;
    end

endmodule

// File: tb/tb_data_mem_stage.sv
// Scoreboarded bench for data_mem_stage: instance a uses MEM_LAT=2,
// instance b uses MEM_LAT=0. Both share clock and reset.
module tb_data_mem_stage;
    logic clock = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    logic [1:0]  a_wb, b_wb;
    logic [2:0]  a_mm, b_mm;
    logic [31:0] a_alu, b_alu, a_wd, b_wd;
    logic [4:0]  a_rdi, b_rdi;
    logic [31:0] a_memalu, b_memalu, a_dtw, b_dtw;
    logic [4:0]  a_emrd, b_emrd, a_mwrd, b_mwrd;
    logic [1:0]  a_emwb, b_emwb, a_mwwb, b_mwwb;
    logic        a_stall, b_stall, a_trap, b_trap;

    data_mem_stage #(.DEPTH(256), .MEM_LAT(2)) u_dut_a (
        .clock(clock), .resetn(resetn), .EXMWB(a_wb), .EXMM(a_mm),
        .EXALUOut(a_alu), .EXMWriteDataIn(a_wd), .regtopass(a_rdi),
        .MEMALUOut(a_memalu), .EXMEMRegRd(a_emrd), .EXMEM_RegWrite(a_emwb),
        .MEMWBRegRd(a_mwrd), .MEMWB_RegWrite(a_mwwb), .datatowrite(a_dtw),
        .stall(a_stall), .trap(a_trap));

    data_mem_stage #(.DEPTH(256), .MEM_LAT(0)) u_dut_b (
        .clock(clock), .resetn(resetn), .EXMWB(b_wb), .EXMM(b_mm),
        .EXALUOut(b_alu), .EXMWriteDataIn(b_wd), .regtopass(b_rdi),
        .MEMALUOut(b_memalu), .EXMEMRegRd(b_emrd), .EXMEM_RegWrite(b_emwb),
        .MEMWBRegRd(b_mwrd), .MEMWB_RegWrite(b_mwwb), .datatowrite(b_dtw),
        .stall(b_stall), .trap(b_trap));

    typedef struct {
        logic [31:0] d;
        logic [1:0]  wb;
        logic [4:0]  rd;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int checks = 0;
    int errors = 0;
    int a_trap_cnt = 0;
    int b_stall_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push(input bit sel, input logic [31:0] d, input logic [1:0] wb, input logic [4:0] rd);
        exp_t e;
        e.d = d; e.wb = wb; e.rd = rd;
        if (sel) qb.push_back(e); else qa.push_back(e);
    endtask

    // Monitor a: every nonzero MEM/WB WB field is one retired instruction
    always @(negedge clock) begin
        if (resetn && a_mwwb != 2'b00) begin
            if (qa.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_unexpected_retire wb=%b rd=%0d data=%h", a_mwwb, a_mwrd, a_dtw);
            end else begin
                exp_t e;
                e = qa.pop_front();
                chk("a_wb_data", a_dtw, e.d);
                chk("a_wb_field", {30'd0, a_mwwb}, {30'd0, e.wb});
                chk("a_wb_rd", {27'd0, a_mwrd}, {27'd0, e.rd});
            end
        end
        if (a_trap) a_trap_cnt++;
    end

    // Monitor b
    always @(negedge clock) begin
        if (resetn && b_mwwb != 2'b00) begin
            if (qb.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected_retire wb=%b rd=%0d data=%h", b_mwwb, b_mwrd, b_dtw);
            end else begin
                exp_t e;
                e = qb.pop_front();
                chk("b_wb_data", b_dtw, e.d);
                chk("b_wb_field", {30'd0, b_mwwb}, {30'd0, e.wb});
                chk("b_wb_rd", {27'd0, b_mwrd}, {27'd0, e.rd});
            end
        end
        if (b_stall) b_stall_cnt++;
    end

    // Present one instruction at a negedge, wait until it is captured into
    // EX/MEM, return on the following negedge. nst = stall cycles waited.
    task automatic issue(input bit sel, input logic [1:0] wb, input logic [2:0] mm,
                         input logic [31:0] alu, input logic [31:0] wd,
                         input logic [4:0] rd, output int nst);
        int guard;
        nst = 0;
        guard = 0;
        if (sel) begin b_wb = wb; b_mm = mm; b_alu = alu; b_wd = wd; b_rdi = rd; end
        else     begin a_wb = wb; a_mm = mm; a_alu = alu; a_wd = wd; a_rdi = rd; end
        while ((sel ? b_stall : a_stall) && guard < 40) begin
            nst++; guard++;
            @(negedge clock);
        end
        if (guard >= 40) begin
            checks++; errors++;
            $display("FAIL issue_timeout sel=%0d alu=%h", sel, alu);
        end
        @(posedge clock);
        @(negedge clock);
        if (sel) begin b_wb = 0; b_mm = 0; b_alu = 0; b_wd = 0; b_rdi = 0; end
        else     begin a_wb = 0; a_mm = 0; a_alu = 0; a_wd = 0; a_rdi = 0; end
    endtask

    task automatic chk_a_zero(input string tag);
        chk({tag, "_memalu"}, a_memalu, 32'd0);
        chk({tag, "_emrd"},   {27'd0, a_emrd}, 32'd0);
        chk({tag, "_emwb"},   {30'd0, a_emwb}, 32'd0);
        chk({tag, "_mwrd"},   {27'd0, a_mwrd}, 32'd0);
        chk({tag, "_mwwb"},   {30'd0, a_mwwb}, 32'd0);
        chk({tag, "_dtw"},    a_dtw, 32'd0);
        chk({tag, "_stall"},  {31'd0, a_stall}, 32'd0);
        chk({tag, "_trap"},   {31'd0, a_trap}, 32'd0);
    endtask

    initial begin
        int n;
        int tbase;
        int guard;
        a_wb = 0; a_mm = 0; a_alu = 0; a_wd = 0; a_rdi = 0;
        b_wb = 0; b_mm = 0; b_alu = 0; b_wd = 0; b_rdi = 0;
        repeat (2) @(negedge clock);
        chk_a_zero("reset");
        resetn = 1'b1;

        // ALU op: EX/MEM visible after one edge, write-back after the next
        issue(0, 2'b01, 3'b000, 32'h1234, 32'h0, 5'd5, n);
        push(0, 32'h1234, 2'b01, 5'd5);
        chk("alu_memaluout", a_memalu, 32'h1234);
        chk("alu_emrd", {27'd0, a_emrd}, 32'd5);
        chk("alu_emwb", {30'd0, a_emwb}, 32'd1);
        issue(0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0, n);
        chk("alu_no_stall", n, 0);
        chk("alu_dtw_next_edge", a_dtw, 32'h1234);
        chk("alu_mwwb", {30'd0, a_mwwb}, 32'd1);

        // Store then load at 0x10, two stall cycles each
        issue(0, 2'b00, 3'b010, 32'h10, 32'hDEADBEEF, 5'd0, n);
        issue(0, 2'b11, 3'b001, 32'h10, 32'h0, 5'd7, n);
        push(0, 32'hDEADBEEF, 2'b11, 5'd7);
        chk("store_stall_cycles", n, 2);
        issue(0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0, n);
        chk("load_stall_cycles", n, 2);

        // Reset in the middle of a store: array keeps its old word
        issue(0, 2'b00, 3'b010, 32'h20, 32'h11111111, 5'd0, n);
        issue(0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0, n);
        issue(0, 2'b00, 3'b010, 32'h20, 32'h00000099, 5'd0, n);
        @(posedge clock);
        @(negedge clock);
        chk("busy_stall_before_reset", {31'd0, a_stall}, 32'd1);
        resetn = 1'b0;
        #1;
        chk_a_zero("midreset");
        @(negedge clock);
        resetn = 1'b1;
        issue(0, 2'b11, 3'b001, 32'h20, 32'h0, 5'd8, n);
        push(0, 32'h11111111, 2'b11, 5'd8);
        issue(0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0, n);

        // Address wrap: 0x400 aliases word 0 in a 256-word array
        issue(0, 2'b00, 3'b010, 32'h400, 32'h000000A5, 5'd0, n);
        issue(0, 2'b11, 3'b001, 32'h000, 32'h0, 5'd9, n);
        push(0, 32'h000000A5, 2'b11, 5'd9);
        issue(0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0, n);

        // Misaligned store to 0x13 (word 0x10), then reload 0x10
        tbase = a_trap_cnt;
        issue(0, 2'b01, 3'b010, 32'h13, 32'h00000077, 5'd4, n);
`ifndef MISALIGN_TRAP_EN
        push(0, 32'h13, 2'b01, 5'd4);
`endif
        issue(0, 2'b11, 3'b001, 32'h10, 32'h0, 5'd10, n);
        chk("misalign_stall_cycles", n, 2);
`ifdef MISALIGN_TRAP_EN
        push(0, 32'hDEADBEEF, 2'b11, 5'd10);
`else
        push(0, 32'h00000077, 2'b11, 5'd10);
`endif
        // Simultaneous read+write returns the pre-write word
        issue(0, 2'b11, 3'b011, 32'h10, 32'h00005555, 5'd11, n);
`ifdef MISALIGN_TRAP_EN
        push(0, 32'hDEADBEEF, 2'b11, 5'd11);
`else
        push(0, 32'h00000077, 2'b11, 5'd11);
`endif
        issue(0, 2'b11, 3'b001, 32'h10, 32'h0, 5'd12, n);
        push(0, 32'h00005555, 2'b11, 5'd12);
        issue(0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0, n);
`ifdef MISALIGN_TRAP_EN
        chk("trap_pulses", a_trap_cnt - tbase, 1);
`else
        chk("trap_pulses", a_trap_cnt - tbase, 0);
`endif

        // Zero-latency instance: back-to-back store/load at 0x40
        issue(1, 2'b00, 3'b010, 32'h40, 32'hCAFE0001, 5'd0, n);
        chk("b_store_no_stall", n, 0);
        issue(1, 2'b11, 3'b001, 32'h40, 32'h0, 5'd3, n);
        push(1, 32'hCAFE0001, 2'b11, 5'd3);
        chk("b_load_no_stall", n, 0);
        issue(1, 2'b01, 3'b000, 32'h0BAD, 32'h0, 5'd6, n);
        push(1, 32'h0BAD, 2'b01, 5'd6);
        issue(1, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0, n);
        issue(1, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0, n);

        guard = 0;
        while ((qa.size() != 0 || qb.size() != 0) && guard < 20) begin
            guard++;
            @(negedge clock);
        end
        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);
        chk("b_stall_never_high", b_stall_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
